// File: rtl/traffic_phase_timer.sv
// traffic_phase_timer - two-road traffic light phase sequencer with a BCD seconds countdown and night flash mode.
module traffic_phase_timer #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int GREEN_SEC  = 25,
  parameter int YELLOW_SEC = 5
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       night_en,
  output logic [2:0] ns_led,
  output logic [2:0] ew_led,
  output logic [7:0] data,
  output logic       sec_tick
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRESC_TOP  = PW'(CLK_FREQ - 1);
  localparam logic [7:0]    GREEN_BCD  = {4'(GREEN_SEC / 10), 4'(GREEN_SEC % 10)};
  localparam logic [7:0]    YELLOW_BCD = {4'(YELLOW_SEC / 10), 4'(YELLOW_SEC % 10)};

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    EW_GREEN  = 3'd2,
    EW_YELLOW = 3'd3,
    FLASH     = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    data_q, data_d;
  logic [2:0]    ns_led_q, ns_led_d;
  logic [2:0]    ew_led_q, ew_led_d;
  logic          sec_tick_q, sec_tick_d;
  logic          tick;
  state_t        next_phase;

  function automatic logic [5:0] lamps_for(input state_t s);
    case (s)
      NS_YELLOW: lamps_for = {3'b010, 3'b100};
      EW_GREEN:  lamps_for = {3'b100, 3'b001};
      EW_YELLOW: lamps_for = {3'b100, 3'b010};
      default:   lamps_for = {3'b001, 3'b100};
    endcase
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) bcd_dec = {v[7:4] - 4'd1, 4'd9};
    else                bcd_dec = {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign tick = (presc_q == PRESC_TOP);

  always_comb begin
    next_phase = NS_GREEN;
    case (state_q)
      NS_GREEN:  next_phase = NS_YELLOW;
      NS_YELLOW: next_phase = EW_GREEN;
      EW_GREEN:  next_phase = EW_YELLOW;
      default:   next_phase = NS_GREEN;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    presc_d    = tick ? '0 : presc_q + PW'(1);
    data_d     = data_q;
    ns_led_d   = ns_led_q;
    ew_led_d   = ew_led_q;
    sec_tick_d = tick;
    case (state_q)
      NS_GREEN, NS_YELLOW, EW_GREEN, EW_YELLOW: begin
        // Night mode takes priority over any decrement or phase advance on this edge.
        if (night_en) begin
          state_d  = FLASH;
          presc_d  = '0;
          data_d   = 8'h00;
          ns_led_d = 3'b010;
          ew_led_d = 3'b010;
        end else if (tick) begin
          if (data_q == 8'h01) begin
            state_d              = next_phase;
            data_d               = (next_phase == NS_YELLOW || next_phase == EW_YELLOW)
                                   ? YELLOW_BCD : GREEN_BCD;
            {ns_led_d, ew_led_d} = lamps_for(next_phase);
          end else begin
            data_d = bcd_dec(data_q);
          end
        end
      end
      FLASH: begin
        if (!night_en) begin
          state_d              = NS_GREEN;
          presc_d              = '0;
          data_d               = GREEN_BCD;
          {ns_led_d, ew_led_d} = lamps_for(NS_GREEN);
        end else if (tick) begin
          ns_led_d = {1'b0, ~ns_led_q[1], 1'b0};
          ew_led_d = {1'b0, ~ns_led_q[1], 1'b0};
        end
      end
      default: begin
        state_d              = NS_GREEN;
        presc_d              = '0;
        data_d               = GREEN_BCD;
        {ns_led_d, ew_led_d} = lamps_for(NS_GREEN);
        sec_tick_d           = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_q    <= NS_GREEN;
      presc_q    <= '0;
      data_q     <= GREEN_BCD;
      ns_led_q   <= 3'b001;
      ew_led_q   <= 3'b100;
      sec_tick_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      data_q     <= data_d;
      ns_led_q   <= ns_led_d;
      ew_led_q   <= ew_led_d;
      sec_tick_q <= sec_tick_d;
    end
  end

  assign ns_led   = ns_led_q;
  assign ew_led   = ew_led_q;
  assign data     = data_q;
  assign sec_tick = sec_tick_q;

endmodule
